// File: rtl/search_window_fetcher.sv
// Search-window responder for 3DRS: reads a 22-pixel line from the mirror-padded
// frame (row or column) and returns it to the estimator as three 64-bit beats.
module search_window_fetcher #(
    parameter int PW     = 1352,
    parameter int PH     = 792,
    parameter int OFFS   = 33,
    parameter int MV_LIM = 33,
    parameter int ADDR_W = 21,
    parameter int NPIX   = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              sel_col,
    input  logic signed [6:0] mv_x,
    input  logic signed [6:0] mv_y,
    input  logic [5:0]        blk_row,
    input  logic [6:0]        blk_col,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [63:0]       out_data,
    output logic              out_we,
    output logic [1:0]        out_beat,
    output logic              busy,
    output logic              done,
    output logic              mv_clamped
);

    if (PW * PH > (1 << ADDR_W)) begin : g_addr_w_check
        $error("ADDR_W too narrow for the padded frame");
    end

    typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

    localparam logic signed [6:0] LIM_P = 7'(MV_LIM);
    localparam logic signed [6:0] LIM_N = 7'(-MV_LIM);
    localparam logic [4:0]        LAST  = 5'(NPIX - 1);

    state_t            state_q;
    logic              sel_col_q, mv_clamped_q;
    logic              mem_rd_q, cap_vld_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [4:0]        rd_cnt_q, cap_cnt_q;
    logic [63:0]       out_data_q;
    logic              out_we_q, done_q;
    logic [1:0]        out_beat_q;
    logic [7:0]        pix_q [NPIX];

    // Clamp and base-address computation on the live request inputs.
    logic signed [6:0]  mvx_c, mvy_c;
    logic signed [7:0]  ofs_x, ofs_y;
    logic               clamp_d;
    logic [ADDR_W-1:0]  row_d, base_d, step;

    always_comb begin
        mvx_c   = (mv_x > LIM_P) ? LIM_P : (mv_x < LIM_N) ? LIM_N : mv_x;
        mvy_c   = (mv_y > LIM_P) ? LIM_P : (mv_y < LIM_N) ? LIM_N : mv_y;
        clamp_d = (mv_x > LIM_P) || (mv_x < LIM_N) || (mv_y > LIM_P) || (mv_y < LIM_N);
        // With the clamp, MV + OFFS is never negative, so the base is formed unsigned.
        ofs_x   = {mvx_c[6], mvx_c} + 8'(OFFS);
        ofs_y   = {mvy_c[6], mvy_c} + 8'(OFFS);
        row_d   = ADDR_W'({blk_row, 4'b0000}) + ADDR_W'($unsigned(ofs_y));
        base_d  = row_d * ADDR_W'(PW) + ADDR_W'({blk_col, 4'b0000}) + ADDR_W'($unsigned(ofs_x));
        step    = sel_col_q ? ADDR_W'(PW) : ADDR_W'(1);
    end

    logic [63:0] beat0, beat1, beat2;
    always_comb begin
        beat0 = '0;
        beat1 = '0;
        beat2 = '0;
        for (int i = 0; i < 8; i++) begin
            beat0[63-8*i -: 8] = pix_q[i];
            beat1[63-8*i -: 8] = pix_q[8+i];
            if (i < NPIX - 16) beat2[63-8*i -: 8] = pix_q[16+i];
        end
    end

    always_ff @(posedge clk) begin
        if (cap_vld_q) pix_q[cap_cnt_q] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sel_col_q    <= 1'b0;
            mv_clamped_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            rd_cnt_q     <= '0;
            cap_cnt_q    <= '0;
            cap_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_we_q     <= 1'b0;
            out_beat_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            cap_vld_q <= mem_rd_q;
            case (state_q)
                IDLE: if (fetch_req) begin
                    sel_col_q    <= sel_col;
                    mv_clamped_q <= clamp_d;
                    mem_rd_q     <= 1'b1;
                    mem_addr_q   <= base_d;
                    rd_cnt_q     <= '0;
                    cap_cnt_q    <= '0;
                    state_q      <= READ;
                end
                READ: begin
                    if (mem_rd_q) begin
                        if (rd_cnt_q == LAST) begin
                            mem_rd_q <= 1'b0;
                        end else begin
                            rd_cnt_q   <= rd_cnt_q + 5'd1;
                            mem_addr_q <= mem_addr_q + step;
                        end
                    end
                    if (cap_vld_q) begin
                        cap_cnt_q <= cap_cnt_q + 5'd1;
                        if (cap_cnt_q == LAST) begin
                            state_q    <= EMIT;
                            out_we_q   <= 1'b1;
                            out_beat_q <= 2'd0;
                            out_data_q <= beat0;
                        end
                    end
                end
                EMIT: begin
                    case (out_beat_q)
                        2'd0: begin
                            out_beat_q <= 2'd1;
                            out_data_q <= beat1;
                        end
                        2'd1: begin
                            out_beat_q <= 2'd2;
                            out_data_q <= beat2;
                            done_q     <= 1'b1;
                        end
                        default: begin
                            out_we_q   <= 1'b0;
                            out_beat_q <= 2'd0;
                            done_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign out_data   = out_data_q;
    assign out_we     = out_we_q;
    assign out_beat   = out_beat_q;
    assign done       = done_q;
    assign mv_clamped = mv_clamped_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_search_window_fetcher.sv
// Scoreboard bench for search_window_fetcher: a line-level reference model queues
// expected read addresses and beats; a negedge monitor pops and compares.
module tb_search_window_fetcher;
    localparam int PW = 1352;
    localparam int PH = 792;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              fetch_req = 1'b0;
    logic              sel_col = 1'b0;
    logic signed [6:0] mv_x = '0;
    logic signed [6:0] mv_y = '0;
    logic [5:0]        blk_row = '0;
    logic [6:0]        blk_col = '0;
    logic              mem_rd;
    logic [20:0]       mem_addr;
    logic [7:0]        mem_rdata = '0;
    logic [63:0]       out_data;
    logic              out_we;
    logic [1:0]        out_beat;
    logic              busy, done, mv_clamped;

    always #5 clk = ~clk;

    search_window_fetcher dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .sel_col(sel_col),
        .mv_x(mv_x), .mv_y(mv_y), .blk_row(blk_row), .blk_col(blk_col),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_we(out_we), .out_beat(out_beat),
        .busy(busy), .done(done), .mv_clamped(mv_clamped)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory: contents are a function of the address, one-cycle read latency.
    int          mem_mode = 0;
    logic [31:0] mem_seed = 32'h1234_5678;
    function automatic logic [7:0] mem_val(input logic [20:0] a);
        logic [31:0] h;
        if (mem_mode == 0) return a[7:0];
        h = ({11'd0, a} ^ mem_seed) * 32'h9E37_79B1;
        return h[23:16];
    endfunction
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_val(mem_addr);

    typedef struct {
        logic [63:0] data;
        logic [1:0]  beat;
        logic        done;
        int          t;
    } beat_t;

    logic [20:0] addr_q[$];
    beat_t       beat_q[$];
    logic        clamp_q[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic bad(input string nm);
        n_chk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference model: line addresses from the block/MV rules, pixels packed MSB-first.
    task automatic push_model(input bit sel, input int mvx, input int mvy,
                              input int row, input int col, input int t_acc);
        int cx, cy, base, a;
        bit cl;
        logic [7:0]  p[22];
        logic [63:0] b0, b1, b2;
        cx = (mvx > 33) ? 33 : (mvx < -33) ? -33 : mvx;
        cy = (mvy > 33) ? 33 : (mvy < -33) ? -33 : mvy;
        cl = (cx != mvx) || (cy != mvy);
        base = (row * 16 + cy + 33) * PW + col * 16 + cx + 33;
        for (int k = 0; k < 22; k++) begin
            a = base + (sel ? k * PW : k);
            addr_q.push_back(21'(a));
            p[k] = mem_val(21'(a));
        end
        b0 = '0; b1 = '0; b2 = '0;
        for (int i = 0; i < 8; i++) begin
            b0 = {b0[55:0], p[i]};
            b1 = {b1[55:0], p[8+i]};
        end
        for (int i = 16; i < 22; i++) b2 = {b2[55:0], p[i]};
        b2 = b2 << 16;
        beat_q.push_back('{data: b0, beat: 2'd0, done: 1'b0, t: 0});
        beat_q.push_back('{data: b1, beat: 2'd1, done: 1'b0, t: 0});
        beat_q.push_back('{data: b2, beat: 2'd2, done: 1'b1, t: t_acc + 25});
        clamp_q.push_back(cl);
    endtask

    task automatic drive(input bit sel, input int mvx, input int mvy, input int row, input int col);
        sel_col = sel;
        mv_x    = 7'(mvx);
        mv_y    = 7'(mvy);
        blk_row = 6'(row);
        blk_col = 7'(col);
    endtask

    task automatic req(input bit sel, input int mvx, input int mvy, input int row, input int col);
        @(negedge clk);
        drive(sel, mvx, mvy, row, col);
        fetch_req = 1'b1;
        push_model(sel, mvx, mvy, row, col, cyc + 1);
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    task automatic wait_idle();
        bool_loop: for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy && addr_q.size() == 0 && beat_q.size() == 0) return;
        end
        bad("wait_idle_timeout");
        addr_q.delete();
        beat_q.delete();
        clamp_q.delete();
    endtask

    // Monitor
    bit          mon_en = 1'b0;
    bit          first_pending = 1'b0;
    int          rd_seen = 0;
    logic [20:0] first_addr = '0, last_addr = '0, max_addr = '0;
    logic [63:0] seen_beat [3];
    beat_t       e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd) begin
                if (addr_q.size() == 0) bad("unexpected_read");
                else chk("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                if (first_pending) begin
                    first_addr    = mem_addr;
                    first_pending = 1'b0;
                end
                last_addr = mem_addr;
                if (mem_addr > max_addr) max_addr = mem_addr;
                rd_seen++;
            end
            if (out_we) begin
                if (beat_q.size() == 0) bad("unexpected_beat");
                else begin
                    e = beat_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_idx", 64'(out_beat), 64'(e.beat));
                    chk("done_flag", 64'(done), 64'(e.done));
                    if (out_beat < 2'd3) seen_beat[out_beat] = out_data;
                    if (e.done) begin
                        chk("done_time", 64'(cyc), 64'(e.t));
                        chk("mv_clamped", 64'(mv_clamped), 64'(clamp_q.pop_front()));
                    end
                end
            end else if (done || out_beat != 2'd0) begin
                bad("done_or_beat_outside_emit");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int tA, n_bad;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ctrl", 64'({busy, out_we, mem_rd, done, mv_clamped, out_beat}), 64'd0);
            chk("idle_data", out_data, 64'd0);
        end
        mon_en = 1'b1;

        // Horizontal line, block (0,0), zero MV, memory = addr[7:0]
        mem_mode = 0;
        first_pending = 1'b1;
        req(0, 0, 0, 0, 0);
        wait_idle();
        chk("h_first_addr", 64'(first_addr), 64'd44649);
        chk("h_last_addr", 64'(last_addr), 64'd44670);
        chk("h_beat0", seen_beat[0], 64'h696A6B6C6D6E6F70);
        chk("h_beat1", seen_beat[1], 64'h7172737475767778);
        chk("h_beat2", seen_beat[2], 64'h797A7B7C7D7E0000);

        // Vertical line, same block
        first_pending = 1'b1;
        req(1, 0, 0, 0, 0);
        wait_idle();
        chk("v_first_addr", 64'(first_addr), 64'd44649);
        chk("v_last_addr", 64'(last_addr), 64'd73041);

        // Both MV components out of range
        first_pending = 1'b1;
        req(0, -64, 63, 0, 0);
        wait_idle();
        chk("clamp_first_addr", 64'(first_addr), 64'd89232);
        chk("clamp_flag", 64'(mv_clamped), 64'd1);

        // Bottom-right block, maximum MV, vertical
        max_addr = '0;
        req(1, 33, 33, 44, 79);
        wait_idle();
        chk("corner_max_addr", 64'(max_addr), 64'd1070762);
        chk("corner_in_frame", 64'(max_addr < 21'(PW * PH)), 64'd1);
        chk("corner_no_clamp", 64'(mv_clamped), 64'd0);

        // Request pulsed again mid-transfer is ignored
        mem_mode = 1;
        mem_seed = $urandom;
        rd_seen = 0;
        req(0, 5, -7, 10, 20);
        repeat (4) @(negedge clk);
        drive(1, -20, 12, 3, 4);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk);
        chk("ignored_req_reads", 64'(rd_seen), 64'd22);

        // Request held high: re-accepted exactly 27 cycles after the first
        @(negedge clk);
        drive(0, 12, 3, 7, 30);
        fetch_req = 1'b1;
        tA = cyc + 1;
        push_model(0, 12, 3, 7, 30, tA);
        @(negedge clk);
        drive(1, -50, 40, 20, 60);
        push_model(1, -50, 40, 20, 60, tA + 27);
        while (cyc < tA + 27) @(negedge clk);
        fetch_req = 1'b0;
        wait_idle();

        // Reset in the middle of a request, with a re-pulse in between
        mon_en = 1'b0;
        @(negedge clk);
        drive(0, 1, 1, 2, 2);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_reset", 64'({busy, out_we, mem_rd, done}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_we || mem_rd || busy) n_bad++;
        end
        chk("post_reset_quiet", 64'(n_bad), 64'd0);
        mon_en = 1'b1;
        mem_mode = 0;
        first_pending = 1'b1;
        req(0, 0, 0, 0, 0);
        wait_idle();
        chk("post_reset_first_addr", 64'(first_addr), 64'd44649);

        // Randomized lines
        mem_mode = 1;
        for (int n = 0; n < 25; n++) begin
            mem_seed = $urandom;
            req(1'($urandom_range(1)), int'($urandom_range(127)) - 64, int'($urandom_range(127)) - 64,
                int'($urandom_range(44)), int'($urandom_range(79)));
            wait_idle();
            if ($urandom_range(1) == 1) repeat (int'($urandom_range(3))) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("queues_drained", 64'(addr_q.size() + beat_q.size() + clamp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
